// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU load-return path.
// - region_e  : decoded target region, RGN_ERR marks unmapped/misaligned loads
// - *_MATCH/*_MASK : region decode on addr[15:0]
// - F3_*      : load funct3 encodings
// - ld_tag_t  : per-load bookkeeping held while the load is outstanding
package lsu_pkg;

  typedef enum logic [1:0] {
    RGN_IP   = 2'd0,
    RGN_OP   = 2'd1,
    RGN_SRAM = 2'd2,
    RGN_ERR  = 2'd3
  } region_e;

  // Region decode on the low address half; upper bits are not part of the map.
  localparam logic [15:0] IP_MATCH   = 16'h7800;
  localparam logic [15:0] IP_MASK    = 16'hFFC0;
  localparam logic [15:0] OP_MATCH   = 16'h7000;
  localparam logic [15:0] OP_MASK    = 16'hFFC0;
  localparam logic [15:0] SRAM_MATCH = 16'h2000;
  localparam logic [15:0] SRAM_MASK  = 16'hE000;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    region_e    region;
    logic [1:0] offset;
    logic [2:0] funct3;
    logic       err;
  } ld_tag_t;

endpackage

// File: rtl/lsu_tag_fifo.sv
// Synchronous FIFO of outstanding-load tags.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset (drops all entries)
//   i_push, i_data : write a tag (caller guarantees not full)
//   i_pop          : drop the head (caller guarantees not empty)
//   o_data         : head tag, valid when !o_empty
//   o_count, o_full, o_empty : occupancy
module lsu_tag_fifo
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  ld_tag_t                  i_data,
  input  logic                     i_pop,
  output ld_tag_t                  o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  ld_tag_t             mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]       count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (i_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({i_push, i_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (i_push) mem_q[wr_ptr_q] <= i_data;
    end
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_count = count_q;
  assign o_full  = (count_q == (PtrW+1)'(DEPTH));
  assign o_empty = (count_q == '0);

endmodule

// File: rtl/lsu_ld_return.sv
// Load-return unit: decodes each load's region, strobes that region, keeps the
// load's tag in a FIFO and, when the region answers, extracts/extends the lane
// and registers the result. Unmapped or misaligned loads skip the region and
// retire as errors once they reach the FIFO head.
// Ports:
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_req_vld/o_req_rdy     : load request handshake
//   i_req_addr/i_req_funct3 : byte address and load type
//   o_rgn_req/o_rgn_addr    : one-hot region strobe and word address (accept cycle)
//   i_rgn_rvld/i_rgn_rdata  : per-region single-cycle response
//   o_ld_vld/o_ld_data/o_ld_err : registered result pulse, data/err held between pulses
module lsu_ld_return
  import lsu_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = 3,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned DATA_W      = 32  // only 32 is supported
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_req_vld,
  output logic                          o_req_rdy,
  input  logic [31:0]                   i_req_addr,
  input  logic [2:0]                    i_req_funct3,
  output logic [NUM_REGIONS-1:0]        o_rgn_req,
  output logic [31:0]                   o_rgn_addr,
  input  logic [NUM_REGIONS-1:0]        i_rgn_rvld,
  input  logic [NUM_REGIONS*DATA_W-1:0] i_rgn_rdata,
  output logic                          o_ld_vld,
  output logic [DATA_W-1:0]             o_ld_data,
  output logic                          o_ld_err
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  region_e             req_rgn;
  logic                req_misal;
  ld_tag_t             req_tag;
  ld_tag_t             head_tag;
  logic [CntW-1:0]     fifo_cnt;
  logic                fifo_full, fifo_empty;
  logic                accept, pop;
  logic                head_rvld;
  logic [DATA_W-1:0]   head_word;
  logic [7:0]          lane_byte;
  logic [15:0]         lane_half;

  logic                ld_vld_q, ld_vld_d;
  logic [DATA_W-1:0]   ld_data_q, ld_data_d;
  logic                ld_err_q, ld_err_d;

  // Request decode: first matching region wins.
  always_comb begin
    req_rgn = RGN_ERR;
    if ((i_req_addr[15:0] & IP_MASK) == IP_MATCH)        req_rgn = RGN_IP;
    else if ((i_req_addr[15:0] & OP_MASK) == OP_MATCH)   req_rgn = RGN_OP;
    else if ((i_req_addr[15:0] & SRAM_MASK) == SRAM_MATCH) req_rgn = RGN_SRAM;

    case (i_req_funct3)
      F3_LB, F3_LBU: req_misal = 1'b0;
      F3_LH, F3_LHU: req_misal = i_req_addr[0];
      F3_LW:         req_misal = |i_req_addr[1:0];
      default:       req_misal = 1'b1;
    endcase

    req_tag.err    = (req_rgn == RGN_ERR) | req_misal;
    req_tag.region = req_tag.err ? RGN_ERR : req_rgn;
    req_tag.offset = i_req_addr[1:0];
    req_tag.funct3 = i_req_funct3;
  end

  // All outstanding entries share one region, so the head stands for all of
  // them. Readiness looks only at current occupancy, never at a same-cycle pop.
  assign o_req_rdy = !fifo_full & ((fifo_cnt == '0) | (head_tag.region == req_tag.region));
  assign accept    = i_req_vld & o_req_rdy;

  always_comb begin
    o_rgn_req = '0;
    for (int r = 0; r < int'(NUM_REGIONS); r++) begin
      o_rgn_req[r] = accept & !req_tag.err & (int'(req_tag.region) == r);
    end
  end
  assign o_rgn_addr = {i_req_addr[31:2], 2'b00};

  lsu_tag_fifo #(
    .DEPTH(DEPTH)
  ) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (accept),
    .i_data  (req_tag),
    .i_pop   (pop),
    .o_data  (head_tag),
    .o_count (fifo_cnt),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Response of the head's region only; other regions' valids are ignored.
  always_comb begin
    head_rvld = 1'b0;
    head_word = '0;
    for (int r = 0; r < int'(NUM_REGIONS); r++) begin
      if (int'(head_tag.region) == r) begin
        head_rvld = i_rgn_rvld[r];
        head_word = i_rgn_rdata[r*DATA_W +: DATA_W];
      end
    end
  end

  // Error entries retire the first cycle they are head.
  assign pop = !fifo_empty & (head_tag.err | head_rvld);

  always_comb begin
    lane_byte = head_word[{head_tag.offset, 3'b000} +: 8];
    lane_half = head_tag.offset[1] ? head_word[31:16] : head_word[15:0];
    case (head_tag.funct3)
      F3_LB:   ld_data_d = {{(DATA_W-8){lane_byte[7]}}, lane_byte};
      F3_LBU:  ld_data_d = {{(DATA_W-8){1'b0}}, lane_byte};
      F3_LH:   ld_data_d = {{(DATA_W-16){lane_half[15]}}, lane_half};
      F3_LHU:  ld_data_d = {{(DATA_W-16){1'b0}}, lane_half};
      default: ld_data_d = head_word;
    endcase
    if (head_tag.err) ld_data_d = '0;
    ld_err_d = head_tag.err;
    ld_vld_d = pop;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ld_vld_q  <= 1'b0;
      ld_data_q <= '0;
      ld_err_q  <= 1'b0;
    end else begin
      ld_vld_q <= ld_vld_d;
      if (pop) begin
        ld_data_q <= ld_data_d;
        ld_err_q  <= ld_err_d;
      end
    end
  end

  assign o_ld_vld  = ld_vld_q;
  assign o_ld_data = ld_data_q;
  assign o_ld_err  = ld_err_q;

endmodule

// File: tb/tb_lsu_ld_return.sv
module tb_lsu_ld_return;

  localparam int NR = 3;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic            i_req_vld;
  logic            o_req_rdy;
  logic [31:0]     i_req_addr;
  logic [2:0]      i_req_funct3;
  logic [NR-1:0]   o_rgn_req;
  logic [31:0]     o_rgn_addr;
  logic [NR-1:0]   i_rgn_rvld;
  logic [NR*32-1:0] i_rgn_rdata;
  logic            o_ld_vld;
  logic [31:0]     o_ld_data;
  logic            o_ld_err;

  int checks = 0;
  int failures = 0;

  lsu_ld_return #(
    .NUM_REGIONS(NR),
    .DEPTH(2),
    .DATA_W(32)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_vld    (i_req_vld),
    .o_req_rdy    (o_req_rdy),
    .i_req_addr   (i_req_addr),
    .i_req_funct3 (i_req_funct3),
    .o_rgn_req    (o_rgn_req),
    .o_rgn_addr   (o_rgn_addr),
    .i_rgn_rvld   (i_rgn_rvld),
    .i_rgn_rdata  (i_rgn_rdata),
    .o_ld_vld     (o_ld_vld),
    .o_ld_data    (o_ld_data),
    .o_ld_err     (o_ld_err)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- reference model (address map / formatting rules) ----------
  function automatic int ref_region(input logic [31:0] a);
    logic [15:0] lo;
    lo = a[15:0];
    if (lo >= 16'h7800 && lo <= 16'h783F) return 0;
    if (lo >= 16'h7000 && lo <= 16'h703F) return 1;
    if (lo >= 16'h2000 && lo <= 16'h3FFF) return 2;
    return 3;
  endfunction

  function automatic bit ref_misaligned(input logic [31:0] a, input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return (a % 2) != 0;
      3'd2:       return (a % 4) != 0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_data(input logic [31:0] w, input logic [31:0] a,
                                           input logic [2:0] f3);
    logic [31:0] off, b, h;
    off = a % 4;
    b = (w >> (off * 8)) % 256;
    h = (w >> ((off / 2) * 16)) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic req_on(input logic [31:0] a, input logic [2:0] f3);
    i_req_vld = 1'b1;
    i_req_addr = a;
    i_req_funct3 = f3;
    #1;
  endtask

  task automatic req_off();
    i_req_vld = 1'b0;
  endtask

  task automatic resp_on(input int r, input logic [31:0] w);
    i_rgn_rvld = '0;
    i_rgn_rvld[r] = 1'b1;
    i_rgn_rdata[r*32 +: 32] = w;
    #1;
  endtask

  task automatic resp_off();
    i_rgn_rvld = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst_n = 1'b0;
    i_req_vld = 1'b0;
    i_req_addr = '0;
    i_req_funct3 = '0;
    i_rgn_rvld = '0;
    i_rgn_rdata = '0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    tick();
    checks++; if (o_ld_vld !== 1'b0) begin failures++;
      $display("FAIL reset_vld: got %b expected 0", o_ld_vld); end
    checks++; if (o_ld_data !== 32'h0) begin failures++;
      $display("FAIL reset_data: got %h expected 00000000", o_ld_data); end
    checks++; if (o_ld_err !== 1'b0) begin failures++;
      $display("FAIL reset_err: got %b expected 0", o_ld_err); end
    checks++; if (o_req_rdy !== 1'b1) begin failures++;
      $display("FAIL reset_rdy: got %b expected 1", o_req_rdy); end
    checks++; if (o_rgn_req !== 3'b000) begin failures++;
      $display("FAIL reset_rgn_req: got %b expected 000", o_rgn_req); end
  endtask

  task automatic test_lw_sram();
    req_on(32'h0000_2004, 3'b010);
    checks++; if (o_rgn_req !== 3'b100) begin failures++;
      $display("FAIL lw_sram_rgn_req: got %b expected 100", o_rgn_req); end
    checks++; if (o_rgn_addr !== 32'h0000_2004) begin failures++;
      $display("FAIL lw_sram_rgn_addr: got %h expected 00002004", o_rgn_addr); end
    tick();
    req_off();
    tick();
    resp_on(2, 32'hDEAD_BEEF);
    checks++; if (o_ld_vld !== 1'b0) begin failures++;
      $display("FAIL lw_sram_early_vld: got %b expected 0", o_ld_vld); end
    tick();
    resp_off();
    checks++; if (o_ld_vld !== 1'b1 || o_ld_data !== 32'hDEAD_BEEF || o_ld_err !== 1'b0) begin
      failures++;
      $display("FAIL lw_sram_result: got vld=%b data=%h err=%b expected vld=1 data=deadbeef err=0",
               o_ld_vld, o_ld_data, o_ld_err); end
    tick();
    checks++; if (o_ld_vld !== 1'b0 || o_ld_data !== 32'hDEAD_BEEF) begin failures++;
      $display("FAIL lw_sram_hold: got vld=%b data=%h expected vld=0 data=deadbeef",
               o_ld_vld, o_ld_data); end
  endtask

  task automatic test_extend();
    logic [31:0] addr_t [3] = '{32'h7003, 32'h7003, 32'h7802};
    logic [2:0]  f3_t   [3] = '{3'b000, 3'b100, 3'b101};
    int          rgn_t  [3] = '{1, 1, 0};
    logic [31:0] word_t [3] = '{32'h80FF_FF12, 32'h80FF_FF12, 32'h8001_1234};
    logic [31:0] exp_t  [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_8001};
    for (int i = 0; i < 3; i++) begin
      req_on(addr_t[i], f3_t[i]);
      checks++; if (o_rgn_req !== 3'(1 << rgn_t[i])) begin failures++;
        $display("FAIL extend%0d_rgn_req: got %b expected %b", i, o_rgn_req, 3'(1 << rgn_t[i])); end
      tick();
      req_off();
      resp_on(rgn_t[i], word_t[i]);
      tick();
      resp_off();
      checks++; if (o_ld_vld !== 1'b1 || o_ld_data !== exp_t[i] || o_ld_err !== 1'b0) begin
        failures++;
        $display("FAIL extend%0d_result: got vld=%b data=%h err=%b expected vld=1 data=%h err=0",
                 i, o_ld_vld, o_ld_data, o_ld_err, exp_t[i]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    req_on(32'h0000_2000, 3'b010);
    tick();
    req_on(32'h0000_2008, 3'b010);
    checks++; if (o_req_rdy !== 1'b1) begin failures++;
      $display("FAIL b2b_second_rdy: got %b expected 1", o_req_rdy); end
    tick();
    req_on(32'h0000_200C, 3'b010);
    resp_on(2, 32'h1111_2222);
    checks++; if (o_req_rdy !== 1'b0 || o_rgn_req !== 3'b000) begin failures++;
      $display("FAIL b2b_full_holdoff: got rdy=%b rgn_req=%b expected rdy=0 rgn_req=000",
               o_req_rdy, o_rgn_req); end
    tick();
    req_off();
    resp_on(2, 32'h3333_4444);
    checks++; if (o_ld_vld !== 1'b1 || o_ld_data !== 32'h1111_2222) begin failures++;
      $display("FAIL b2b_first: got vld=%b data=%h expected vld=1 data=11112222",
               o_ld_vld, o_ld_data); end
    checks++; if (o_req_rdy !== 1'b1) begin failures++;
      $display("FAIL b2b_rdy_after_pop: got %b expected 1", o_req_rdy); end
    tick();
    resp_off();
    checks++; if (o_ld_vld !== 1'b1 || o_ld_data !== 32'h3333_4444) begin failures++;
      $display("FAIL b2b_second: got vld=%b data=%h expected vld=1 data=33334444",
               o_ld_vld, o_ld_data); end
    tick();
    checks++; if (o_ld_vld !== 1'b0) begin failures++;
      $display("FAIL b2b_end: got vld=%b expected 0", o_ld_vld); end
  endtask

  task automatic test_region_block();
    req_on(32'h0000_2010, 3'b010);
    tick();
    req_on(32'h0000_7800, 3'b010);
    resp_on(0, 32'h5555_AAAA);  // stray IP response
    checks++; if (o_req_rdy !== 1'b0 || o_rgn_req !== 3'b000) begin failures++;
      $display("FAIL block_rdy: got rdy=%b rgn_req=%b expected rdy=0 rgn_req=000",
               o_req_rdy, o_rgn_req); end
    tick();
    checks++; if (o_ld_vld !== 1'b0) begin failures++;
      $display("FAIL block_stray: got vld=%b expected 0", o_ld_vld); end
    resp_on(2, 32'h0BAD_F00D);
    checks++; if (o_req_rdy !== 1'b0) begin failures++;
      $display("FAIL block_pop_rdy: got %b expected 0", o_req_rdy); end
    tick();
    resp_off();
    #1;
    checks++; if (o_ld_vld !== 1'b1 || o_ld_data !== 32'h0BAD_F00D) begin failures++;
      $display("FAIL block_sram_done: got vld=%b data=%h expected vld=1 data=0badf00d",
               o_ld_vld, o_ld_data); end
    checks++; if (o_req_rdy !== 1'b1 || o_rgn_req !== 3'b001) begin failures++;
      $display("FAIL block_ip_accept: got rdy=%b rgn_req=%b expected rdy=1 rgn_req=001",
               o_req_rdy, o_rgn_req); end
    tick();
    req_off();
    resp_on(0, 32'h7777_8888);
    tick();
    resp_off();
    checks++; if (o_ld_vld !== 1'b1 || o_ld_data !== 32'h7777_8888) begin failures++;
      $display("FAIL block_ip_done: got vld=%b data=%h expected vld=1 data=77778888",
               o_ld_vld, o_ld_data); end
    tick();
  endtask

  task automatic test_err();
    logic [31:0] addr_t [2] = '{32'h0000_8000, 32'h0000_2001};
    logic [2:0]  f3_t   [2] = '{3'b010, 3'b001};
    for (int i = 0; i < 2; i++) begin
      req_on(addr_t[i], f3_t[i]);
      checks++; if (o_rgn_req !== 3'b000 || o_req_rdy !== 1'b1) begin failures++;
        $display("FAIL err%0d_no_req: got rgn_req=%b rdy=%b expected rgn_req=000 rdy=1",
                 i, o_rgn_req, o_req_rdy); end
      tick();
      req_off();
      checks++; if (o_ld_vld !== 1'b0) begin failures++;
        $display("FAIL err%0d_early: got vld=%b expected 0", i, o_ld_vld); end
      tick();
      checks++; if (o_ld_vld !== 1'b1 || o_ld_data !== 32'h0 || o_ld_err !== 1'b1) begin
        failures++;
        $display("FAIL err%0d_result: got vld=%b data=%h err=%b expected vld=1 data=0 err=1",
                 i, o_ld_vld, o_ld_data, o_ld_err); end
      tick();
      checks++; if (o_ld_vld !== 1'b0 || o_ld_err !== 1'b1) begin failures++;
        $display("FAIL err%0d_hold: got vld=%b err=%b expected vld=0 err=1",
                 i, o_ld_vld, o_ld_err); end
    end
  endtask

  task automatic test_reset_mid();
    req_on(32'h0000_2000, 3'b010);
    tick();
    req_on(32'h0000_2004, 3'b010);
    resp_on(2, 32'h1234_5678);
    tick();
    resp_off();
    req_on(32'h0000_2008, 3'b010);
    tick();
    req_off();
    // Two loads outstanding, result register holds the first completion.
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_ld_vld !== 1'b0 || o_ld_data !== 32'h0 || o_ld_err !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_outputs: got vld=%b data=%h err=%b expected all 0",
               o_ld_vld, o_ld_data, o_ld_err); end
    checks++; if (o_req_rdy !== 1'b1) begin failures++;
      $display("FAIL rstmid_rdy: got %b expected 1", o_req_rdy); end
    #2;
    i_rst_n = 1'b1;
    tick();
    resp_on(2, 32'hCAFE_F00D);
    tick();
    resp_off();
    checks++; if (o_ld_vld !== 1'b0 || o_ld_data !== 32'h0) begin failures++;
      $display("FAIL rstmid_late_resp: got vld=%b data=%h expected vld=0 data=0",
               o_ld_vld, o_ld_data); end
    tick();
  endtask

  task automatic test_random();
    logic [2:0]  f3_tab [12] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5,
                                 3'd3, 3'd6};
    logic [15:0] lo;
    logic [31:0] addr, word, exp_d;
    logic [2:0]  f3;
    logic [2:0]  exp_req;
    int          rg, lat, other;
    bit          err;
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(3, 0))
        0:       lo = 16'h7800 + 16'($urandom_range(63, 0));
        1:       lo = 16'h7000 + 16'($urandom_range(63, 0));
        2:       lo = 16'h2000 + 16'($urandom_range(16'h1FFF, 0));
        default: lo = 16'h4000 + 16'($urandom_range(16'h2FFF, 0));
      endcase
      addr = {16'($urandom), lo};
      f3 = f3_tab[$urandom_range(11, 0)];
      word = $urandom;
      rg = ref_region(addr);
      err = (rg == 3) || ref_misaligned(addr, f3);
      exp_req = err ? 3'b000 : 3'(1 << rg);
      req_on(addr, f3);
      checks++; if (o_req_rdy !== 1'b1 || o_rgn_req !== exp_req) begin failures++;
        $display("FAIL rand%0d_issue: got rdy=%b rgn_req=%b expected rdy=1 rgn_req=%b addr=%h f3=%0d",
                 it, o_req_rdy, o_rgn_req, exp_req, addr, f3); end
      tick();
      req_off();
      if (err) begin
        exp_d = 32'h0;
        tick();
      end else begin
        exp_d = ref_data(word, addr, f3);
        lat = $urandom_range(3, 1);
        for (int k = 1; k <= lat; k++) begin
          if (k == lat) resp_on(rg, word);
          else if ($urandom_range(1, 0) == 1) begin
            other = (rg + 1 + $urandom_range(1, 0)) % 3;
            resp_on(other, $urandom);
          end
          checks++; if (o_ld_vld !== 1'b0) begin failures++;
            $display("FAIL rand%0d_wait%0d: got vld=%b expected 0", it, k, o_ld_vld); end
          tick();
          resp_off();
        end
      end
      checks++; if (o_ld_vld !== 1'b1 || o_ld_data !== exp_d || o_ld_err !== err) begin
        failures++;
        $display("FAIL rand%0d_result: got vld=%b data=%h err=%b expected vld=1 data=%h err=%b addr=%h f3=%0d",
                 it, o_ld_vld, o_ld_data, o_ld_err, exp_d, err, addr, f3); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_lw_sram();
    test_extend();
    test_back_to_back();
    test_region_block();
    test_err();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_ld_return.md
# lsu_ld_return

Load-return unit for the LSU: accepts load requests, decodes the target memory region, issues a per-region request, and tracks up to DEPTH outstanding loads. It returns each region's read data in order, with byte/halfword lane extraction and sign/zero extension. It replaces the purely combinational load-data selector. Unlike that selector, it supports variable-latency regions (SRAM), flags unmapped and misaligned accesses instead of returning peripheral data, and registers the result. It sits between the LSU address stage and the writeback mux.

## Interface
Parameters:
- NUM_REGIONS, 3: number of decoded regions (IP, OP, SRAM); the map lives in lsu_pkg.
- DEPTH, 2: outstanding-load FIFO depth (power of 2, ≥2).
- DATA_W, 32: data width. Only 32 is supported.

Ports:
- i_clk  in  1  clock. Single clock domain.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_req_vld  in  1  load request valid.
- o_req_rdy  out  1  request can be accepted.
- i_req_addr  in  32  byte address.
- i_req_funct3  in  3  LB=000, LH=001, LW=010, LBU=100, LHU=101.
- o_rgn_req  out  NUM_REGIONS  one-hot read strobe, asserted in the accept cycle.
- o_rgn_addr  out  32  word address {i_req_addr[31:2],2'b00}, valid with o_rgn_req.
- i_rgn_rvld  in  NUM_REGIONS  per-region read-data valid, 1 cycle.
- i_rgn_rdata  in  NUM_REGIONS×32  per-region read word.
- o_ld_vld  out  1  result valid, 1-cycle pulse.
- o_ld_data  out  32  extended load result.
- o_ld_err  out  1  unmapped or misaligned, qualified by o_ld_vld.

## Operation
- Region decode, first match wins:
  - IP: addr[15:6]=10'b0111100000, i.e. 0x7800–0x783F.
  - OP: addr[15:6]=10'b0111000000, i.e. 0x7000–0x703F.
  - SRAM: addr[15:13]=3'b001, i.e. 0x2000–0x3FFF.
  - Anything else is unmapped.
- Misaligned cases: LH/LHU with addr[0]=1; LW with addr[1:0]≠0. Any other funct3 is treated as misaligned.
- Accept condition: i_req_vld & o_req_rdy.
- o_req_rdy = (count<DEPTH) & (count==0 | decoded region == region of all outstanding entries). Unmapped/misaligned requests count as region ERR and also match only ERR. A pop in the same cycle does not raise o_req_rdy.
- On accept, push {region, addr[1:0], funct3, err} into the FIFO. o_rgn_req[region] is asserted only for mapped, aligned requests.
- Completion of the head entry:
  - Mapped entry: completes when i_rgn_rvld[head.region]=1.
  - ERR entry: completes in the first cycle it is head.
  - In both cases the entry is popped and the result is registered.
- Result formatting: LB/LBU select byte addr[1:0]; LH/LHU select halfword addr[1]; LW passes the word. LB and LH sign-extend; LBU and LHU zero-extend. For ERR entries, data=0 and o_ld_err=1.
- i_rgn_rvld with an empty FIFO, or from a region other than the head's, is ignored (no pop, no output).
- Regions must return responses in request order. The single-region-outstanding rule guarantees global order.

## Timing
- Reset values: o_ld_vld=0, o_ld_data=0, o_ld_err=0, FIFO empty (o_req_rdy=1), o_rgn_req=0.
- o_rgn_req and o_rgn_addr are combinational from the accept, in cycle T.
- Region response at T+k (k≥1) produces o_ld_vld at T+k+1.
- An ERR request accepted into an empty FIFO at T becomes head at T+1 and produces o_ld_vld at T+2.
- Back-to-back completions give one o_ld_vld per cycle. o_ld_data/o_ld_err hold their last value while o_ld_vld=0.
- Full FIFO: o_req_rdy=0 until the cycle after a pop.
- Reset mid-operation: all entries are dropped. Responses arriving after reset are treated as stray and ignored.

## Structure
- lsu_pkg holds:
  - the region_e enum {RGN_IP, RGN_OP, RGN_SRAM, RGN_ERR};
  - region match value/mask constants;
  - funct3 localparams;
  - the packed ld_tag_t struct {region, offset[1:0], funct3, err}.
- Sub-module lsu_tag_fifo: a parametrised synchronous FIFO of ld_tag_t with count, full and empty. It is the only storage besides the output register.
- Decode, extension and the output register live in lsu_ld_return.

## Test plan
- LW 0x2004, SRAM rvld 2 cycles after accept with 0xDEADBEEF → o_ld_vld at T+3, data 0xDEADBEEF, err=0.
- LB 0x7003, OP returns 0x80FF_FF12 at T+1 → data 0xFFFFFF80. LBU same → 0x00000080. LHU 0x7802 from IP 0x8001_1234 → 0x00008001.
- Two SRAM LWs back-to-back, responses in consecutive cycles → two consecutive o_ld_vld pulses in order. A third request is held off (o_req_rdy=0) with DEPTH=2.
- SRAM load outstanding, then a request to IP → rdy=0 until the SRAM completion pops. Stray IP rvld meanwhile → no output.
- LW 0x8000 (unmapped) → no o_rgn_req, o_ld_vld at T+2, data 0, err=1. LH 0x2001 → err=1.
- Assert i_rst_n=0 with 2 loads outstanding → outputs go to 0 immediately. Late SRAM rvld after release → ignored.
